// File: rtl/controle_cronometro_if.sv
// Stopwatch control bundle: raw active-low push-buttons in, counter/display control out.
interface controle_cronometro_if;
    logic       key_start_stop_n;
    logic       key_clear_n;
    logic       key_lap_n;
    logic       enable;
    logic       clear_n;
    logic       lap_freeze;
    logic [1:0] state;

    modport master (
        output key_start_stop_n,
        output key_clear_n,
        output key_lap_n,
        input  enable,
        input  clear_n,
        input  lap_freeze,
        input  state
    );

    modport slave (
        input  key_start_stop_n,
        input  key_clear_n,
        input  key_lap_n,
        output enable,
        output clear_n,
        output lap_freeze,
        output state
    );
endinterface

// File: rtl/controle_cronometro.sv
// Stopwatch control: per-button sync + debounce + press detect, feeding a 4-state
// run/pause/lap FSM whose registered outputs drive the counter and display path.
module controle_cronometro #(
    parameter int DEBOUNCE_TICKS = 2
) (
    input  logic                 clk_100hz,
    input  logic                 reset,
    controle_cronometro_if.slave bus
);

    localparam int         NKEYS     = 3;
    localparam logic [3:0] DEB_LIMIT = 4'(DEBOUNCE_TICKS);

    // Button index: 0 = start/stop, 1 = clear, 2 = lap.
    logic [NKEYS-1:0] key_raw;
    logic [NKEYS-1:0] key_press;

    assign key_raw = {bus.key_lap_n, bus.key_clear_n, bus.key_start_stop_n};

    genvar gi;
    generate
        for (gi = 0; gi < NKEYS; gi++) begin : g_key
            logic       sync1_q;
            logic       sync2_q;
            logic       level_q;
            logic       level_d;
            logic [3:0] cnt_q;
            logic [3:0] cnt_d;
            logic       press_q;
            logic       press_d;

            always_comb begin
                level_d = level_q;
                cnt_d   = 4'd0;
                if (sync2_q != level_q) begin
                    if (cnt_q + 4'd1 >= DEB_LIMIT) begin
                        level_d = sync2_q;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                // Only the released->pressed transition of the accepted level counts.
                press_d = level_q & ~level_d;
            end

            always_ff @(posedge clk_100hz or negedge reset) begin
                if (!reset) begin
                    sync1_q <= 1'b1;
                    sync2_q <= 1'b1;
                    level_q <= 1'b1;
                    cnt_q   <= 4'd0;
                    press_q <= 1'b0;
                end else begin
                    sync1_q <= key_raw[gi];
                    sync2_q <= sync1_q;
                    level_q <= level_d;
                    cnt_q   <= cnt_d;
                    press_q <= press_d;
                end
            end

            assign key_press[gi] = press_q;
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUNNING = 2'b01,
        ST_PAUSED  = 2'b10,
        ST_LAP     = 2'b11
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   enable_q;
    logic   enable_d;
    logic   clear_n_q;
    logic   clear_n_d;
    logic   lap_freeze_q;
    logic   lap_freeze_d;

    // Same-cycle events resolve clear > start/stop > lap; losers are dropped.
    logic ev_clear;
    logic ev_start_stop;
    logic ev_lap;

    assign ev_clear      = key_press[1];
    assign ev_start_stop = key_press[0] & ~key_press[1];
    assign ev_lap        = key_press[2] & ~key_press[1] & ~key_press[0];

    always_ff @(posedge clk_100hz or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            enable_q     <= 1'b0;
            clear_n_q    <= 1'b1;
            lap_freeze_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            enable_q     <= enable_d;
            clear_n_q    <= clear_n_d;
            lap_freeze_q <= lap_freeze_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (ev_start_stop) state_d = ST_RUNNING;
            end
            ST_RUNNING: begin
                if (ev_start_stop)  state_d = ST_PAUSED;
                else if (ev_lap)    state_d = ST_LAP;
            end
            ST_LAP: begin
                if (ev_start_stop)  state_d = ST_PAUSED;
                else if (ev_lap)    state_d = ST_RUNNING;
            end
            ST_PAUSED: begin
                if (ev_clear)           state_d = ST_IDLE;
                else if (ev_start_stop) state_d = ST_RUNNING;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they land together with it.
    always_comb begin
        enable_d     = (state_d == ST_RUNNING) || (state_d == ST_LAP);
        lap_freeze_d = (state_d == ST_LAP);
        clear_n_d    = ~(ev_clear && ((state_q == ST_IDLE) || (state_q == ST_PAUSED)));
    end

    assign bus.enable     = enable_q;
    assign bus.clear_n    = clear_n_q;
    assign bus.lap_freeze = lap_freeze_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_controle_cronometro.sv
// Scoreboard bench: stimulus queues expected output changes with their arrival cycle,
// a monitor pops one entry each time the observed outputs change.
module tb_controle_cronometro;

    localparam int DEB = 2;
    localparam int LAT = 3 + DEB;   // key-down cycle to output change

    logic clk_100hz = 1'b0;
    logic reset     = 1'b0;
    int   cycle     = 0;
    int   n_checks  = 0;
    int   n_fail    = 0;

    controle_cronometro_if bus ();

    controle_cronometro #(.DEBOUNCE_TICKS(DEB)) dut (
        .clk_100hz (clk_100hz),
        .reset     (reset),
        .bus       (bus)
    );

    always #5 clk_100hz = ~clk_100hz;
    always @(posedge clk_100hz) cycle = cycle + 1;

    typedef struct {
        logic [4:0] val;    // {enable, clear_n, lap_freeze, state}
        int         cyc;
        string      name;
    } exp_t;

    exp_t exp_q[$];

    localparam logic [4:0] V_RESET   = 5'b0_1_0_00;
    localparam logic [4:0] V_IDLE    = 5'b0_1_0_00;
    localparam logic [4:0] V_CLRPULS = 5'b0_0_0_00;
    localparam logic [4:0] V_RUN     = 5'b1_1_0_01;
    localparam logic [4:0] V_PAUSE   = 5'b0_1_0_10;
    localparam logic [4:0] V_LAP     = 5'b1_1_1_11;

    localparam logic [2:0] K_SS  = 3'b001;
    localparam logic [2:0] K_CLR = 3'b010;
    localparam logic [2:0] K_LAP = 3'b100;

    function automatic logic [4:0] outs();
        return {bus.enable, bus.clear_n, bus.lap_freeze, bus.state};
    endfunction

    function automatic void push(input logic [4:0] v, input int c, input string n);
        exp_t e;
        e.val  = v;
        e.cyc  = c;
        e.name = n;
        exp_q.push_back(e);
    endfunction

    task automatic set_keys(input logic [2:0] mask, input logic level, output int t0);
        @(posedge clk_100hz);
        #1;
        t0 = cycle;
        if (mask[0]) bus.key_start_stop_n = level;
        if (mask[1]) bus.key_clear_n      = level;
        if (mask[2]) bus.key_lap_n        = level;
    endtask

    task automatic press(input logic [2:0] mask, input int hold, input int settle);
        int t;
        set_keys(mask, 1'b1, t);   // align to a clock edge; keys are already high
        t = 0;
        repeat (hold) @(posedge clk_100hz);
        set_keys(mask, 1'b1, t);
        repeat (settle) @(posedge clk_100hz);
    endtask

    // Monitor: compare each observed output change against the queue head.
    initial begin
        logic [4:0] prev;
        logic [4:0] cur;
        exp_t       e;
        @(negedge clk_100hz);
        prev = outs();
        n_checks++;
        if (prev !== V_RESET) begin
            n_fail++;
            $display("FAIL reset_values: got %b, required %b", prev, V_RESET);
        end
        forever begin
            @(negedge clk_100hz);
            cur = outs();
            if (cur !== prev) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change: cycle %0d got %b (was %b), none required",
                             cycle, cur, prev);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e.val || cycle != e.cyc) begin
                        n_fail++;
                        $display("FAIL %s: got %b at cycle %0d, required %b at cycle %0d",
                                 e.name, cur, cycle, e.val, e.cyc);
                    end else begin
                        $display("ok   %s: %b at cycle %0d", e.name, cur, cycle);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin
        int t;
        bus.key_start_stop_n = 1'b1;
        bus.key_clear_n      = 1'b1;
        bus.key_lap_n        = 1'b1;

        repeat (3) @(posedge clk_100hz);
        #1 reset = 1'b1;
        repeat (20) @(posedge clk_100hz);

        // Start, then pause; releases must not cause transitions.
        set_keys(K_SS, 1'b0, t);  push(V_RUN, t + LAT, "ss_run");
        repeat (10) @(posedge clk_100hz);
        set_keys(K_SS, 1'b1, t);  repeat (8) @(posedge clk_100hz);
        set_keys(K_SS, 1'b0, t);  push(V_PAUSE, t + LAT, "ss_pause");
        repeat (10) @(posedge clk_100hz);
        set_keys(K_SS, 1'b1, t);  repeat (8) @(posedge clk_100hz);

        // Clear from PAUSED: single-cycle pulse and back to IDLE.
        set_keys(K_CLR, 1'b0, t);
        push(V_CLRPULS, t + LAT, "clr_paused_pulse");
        push(V_IDLE, t + LAT + 1, "clr_paused_end");
        repeat (6) @(posedge clk_100hz);
        set_keys(K_CLR, 1'b1, t); repeat (8) @(posedge clk_100hz);

        // One-cycle glitch is rejected, two-cycle low is accepted.
        set_keys(K_SS, 1'b0, t);
        set_keys(K_SS, 1'b1, t);  repeat (10) @(posedge clk_100hz);
        set_keys(K_SS, 1'b0, t);  push(V_RUN, t + LAT, "glitch2_run");
        @(posedge clk_100hz);
        set_keys(K_SS, 1'b1, t);  repeat (10) @(posedge clk_100hz);

        // Clear while RUNNING is ignored.
        set_keys(K_CLR, 1'b0, t); repeat (6) @(posedge clk_100hz);
        set_keys(K_CLR, 1'b1, t); repeat (8) @(posedge clk_100hz);

        // Lap in, lap out, lap in again, then start/stop out of LAP.
        set_keys(K_LAP, 1'b0, t); push(V_LAP, t + LAT, "lap_enter");
        repeat (6) @(posedge clk_100hz);
        set_keys(K_LAP, 1'b1, t); repeat (8) @(posedge clk_100hz);
        set_keys(K_LAP, 1'b0, t); push(V_RUN, t + LAT, "lap_exit");
        repeat (6) @(posedge clk_100hz);
        set_keys(K_LAP, 1'b1, t); repeat (8) @(posedge clk_100hz);
        set_keys(K_LAP, 1'b0, t); push(V_LAP, t + LAT, "lap_enter2");
        repeat (6) @(posedge clk_100hz);
        set_keys(K_LAP, 1'b1, t); repeat (8) @(posedge clk_100hz);
        set_keys(K_SS, 1'b0, t);  push(V_PAUSE, t + LAT, "lap_to_pause");
        repeat (6) @(posedge clk_100hz);
        set_keys(K_SS, 1'b1, t);  repeat (8) @(posedge clk_100hz);

        // Clear and start/stop together in PAUSED: clear wins.
        set_keys(K_SS | K_CLR, 1'b0, t);
        push(V_CLRPULS, t + LAT, "simul_clr_pulse");
        push(V_IDLE, t + LAT + 1, "simul_clr_end");
        repeat (6) @(posedge clk_100hz);
        set_keys(K_SS | K_CLR, 1'b1, t); repeat (8) @(posedge clk_100hz);

        // Reach LAP, then assert reset between clock edges.
        set_keys(K_SS, 1'b0, t);  push(V_RUN, t + LAT, "pre_rst_run");
        repeat (6) @(posedge clk_100hz);
        set_keys(K_SS, 1'b1, t);  repeat (8) @(posedge clk_100hz);
        set_keys(K_LAP, 1'b0, t); push(V_LAP, t + LAT, "pre_rst_lap");
        repeat (6) @(posedge clk_100hz);
        set_keys(K_LAP, 1'b1, t); repeat (8) @(posedge clk_100hz);

        @(posedge clk_100hz);
        #2;
        push(V_RESET, cycle, "rst_async");
        reset = 1'b0;
        #1;
        n_checks++;
        if (outs() !== V_RESET) begin
            n_fail++;
            $display("FAIL rst_async_immediate: got %b, required %b", outs(), V_RESET);
        end
        repeat (3) @(posedge clk_100hz);
        #1 reset = 1'b1;
        repeat (15) @(posedge clk_100hz);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_expectations: %0d left, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/controle_cronometro.md
Name: controle_cronometro

Overview:
- Control stage directly upstream of the stopwatch counter (contador_cronometro).
- Runs on the 100 Hz tick clock and takes the three raw active-low board push-buttons: start/stop, clear and lap.
- Synchronizes and debounces each button, detects press edges and runs a 4-state FSM.
- Drives the counter's enable, a one-cycle active-low clear pulse, and a lap-freeze flag for the display path.

Parameters:
- DEBOUNCE_TICKS, 2, consecutive stable synchronized samples (10 ms each) required to accept a level change; legal range 1..15.

Ports:
- clk_100hz  input  1  100 Hz clock from divisor_clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- key_start_stop_n  input  1  raw start/stop button, asynchronous, low = pressed.
- key_clear_n  input  1  raw clear button, asynchronous, low = pressed.
- key_lap_n  input  1  raw lap button, asynchronous, low = pressed.
- enable  output  1  count enable to the counter; registered.
- clear_n  output  1  active-low one-cycle clear pulse to the counter; registered; top level ANDs it with reset.
- lap_freeze  output  1  high = display holds the last latched time; registered.
- state  output  2  current FSM state for debug LEDs: 00 IDLE, 01 RUNNING, 10 PAUSED, 11 LAP.

Behaviour:
- Reset values (while reset is low):
  - sync flops = 1; debounced levels = 1 (released); debounce counters = 0.
  - FSM = IDLE; enable = 0; clear_n = 1; lap_freeze = 0; state = 00.
- Synchronizer: 2-flop chain per button.
- Debounce, per button:
  - Counter clears whenever the synchronized value equals the debounced level.
  - Otherwise it increments each cycle; on reaching DEBOUNCE_TICKS, the debounced level takes the synchronized value and the counter clears.
  - Glitches shorter than DEBOUNCE_TICKS cycles are discarded.
- Press event: one-cycle pulse when a debounced level goes 1->0. Release produces no event. A held button produces exactly one event.
- A button held through reset yields one press event after sync + debounce delay once reset is released.
- Latency: raw falling edge to press event = 2 (sync) + DEBOUNCE_TICKS cycles. The FSM transition and all outputs update on the clock edge after the event cycle.
- Event priority in a single cycle: clear > start_stop > lap. The lower-priority events are dropped, not queued.
- FSM transitions:
  - IDLE: start_stop -> RUNNING. Clear -> IDLE with clear pulse. Lap ignored.
  - RUNNING: start_stop -> PAUSED. Lap -> LAP. Clear ignored (no pulse).
  - LAP: lap -> RUNNING. start_stop -> PAUSED. Clear ignored.
  - PAUSED: start_stop -> RUNNING. Clear -> IDLE with clear pulse. Lap ignored.
- Outputs are registered decodes of the next state:
  - enable = 1 in RUNNING and LAP (time keeps counting during lap).
  - lap_freeze = 1 only in LAP. Entering PAUSED from LAP drops the freeze, so the display shows the live paused value.
  - clear_n = 0 for exactly one cycle, in the cycle after an accepted clear event; otherwise 1. Glitch-free.
- No combinational path from any key input to any output.
- Reset asserted mid-operation, including mid-debounce or mid clear pulse: immediately forces the reset values. An in-flight debounce count is lost.

Test Plan (DEBOUNCE_TICKS = 2):
- Reset release, no keys -> enable = 0, clear_n = 1, lap_freeze = 0, state = 00 held for 20 cycles.
- key_start_stop_n low at cycle 10, held 10 cycles:
  - enable rises 5 cycles later; state = 01.
  - Second identical press -> enable = 0, state = 10.
  - Release generates no transition.
- 1-cycle and 2-cycle low glitches on key_start_stop_n at DEBOUNCE_TICKS = 2 -> 1-cycle glitch causes no transition. The 2-cycle glitch is accepted (boundary check): state 00 -> 01.
- Clear handling:
  - In PAUSED, press key_clear_n -> clear_n low exactly 1 cycle, state 10 -> 00, enable stays 0.
  - In RUNNING, the same press -> clear_n stays 1, state stays 01.
- Lap sequence RUNNING -> lap -> LAP (lap_freeze = 1, enable = 1) -> lap -> RUNNING (lap_freeze = 0). Repeat, then start_stop from LAP -> PAUSED, lap_freeze = 0.
- Simultaneous and reset cases:
  - key_clear_n and key_start_stop_n pressed in the same cycle in PAUSED -> IDLE with clear pulse, no RUNNING.
  - Reset pulsed while in LAP -> outputs return to reset values asynchronously, with no clock edge required.
